// File: rtl/exe_cmd_driver_if.sv
// Command, exe-unit and result-FIFO signal bundle for exe_cmd_driver.
// Latency: none (wires only); names keep the driver's i_/o_ direction view.
// Backpressure: valid/ready on both the command side and the result side.
interface exe_cmd_driver_if #(
    parameter int BITS = 8
);
    logic            i_cmd_valid;
    logic            o_cmd_ready;
    logic [BITS-1:0] i_cmd_a;
    logic [BITS-1:0] i_cmd_b;
    logic [1:0]      i_cmd_op;
    logic [BITS-1:0] o_exe_a;
    logic [BITS-1:0] o_exe_b;
    logic [1:0]      o_exe_op;
    logic [BITS-1:0] i_exe_out;
    logic [3:0]      i_exe_status;
    logic            o_res_valid;
    logic            i_res_ready;
    logic [BITS-1:0] o_res_data;
    logic [3:0]      o_res_status;
    logic [7:0]      o_err_cnt;
    logic            o_chk_fail;

    // The driver itself.
    modport slave (
        input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
        input  i_exe_out, i_exe_status, i_res_ready,
        output o_cmd_ready, o_exe_a, o_exe_b, o_exe_op,
        output o_res_valid, o_res_data, o_res_status, o_err_cnt, o_chk_fail
    );

    // Command source, exe unit and result consumer around the driver.
    modport master (
        output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
        output i_exe_out, i_exe_status, i_res_ready,
        input  o_cmd_ready, o_exe_a, o_exe_b, o_exe_op,
        input  o_res_valid, o_res_data, o_res_status, o_err_cnt, o_chk_fail
    );
endinterface

// File: rtl/exe_cmd_driver.sv
// Drives one command into the exe unit, captures {result,status} into a FWFT result FIFO.
// Latency: handshake at edge N, FIFO push at edge N+2; at most one command in flight.
// Backpressure: o_cmd_ready drops while busy or FIFO full; optional flag checker under EXE_DRV_CHECK_EN.

`ifndef OVF_BIT
`define OVF_BIT 0
`endif
`ifndef ERROR_BIT
`define ERROR_BIT 1
`endif
`ifndef EVEN_BIT
`define EVEN_BIT 2
`endif
`ifndef SINGLE_BIT
`define SINGLE_BIT 3
`endif

module exe_cmd_driver #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    exe_cmd_driver_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EVAL
    } state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] exe_a_q, exe_a_d;
    logic [BITS-1:0] exe_b_q, exe_b_d;
    logic [1:0]      exe_op_q, exe_op_d;

    logic [BITS-1:0] mem_data_q [DEPTH];
    logic [3:0]      mem_stat_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic            cmd_ready;
    logic            push;
    logic            pop;

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign pop        = !fifo_empty && bus.i_res_ready;

    // Sequencer: accept in IDLE, give the exe unit one edge to sample, capture on the next.
    always_comb begin
        state_d   = state_q;
        exe_a_d   = exe_a_q;
        exe_b_d   = exe_b_q;
        exe_op_d  = exe_op_q;
        cmd_ready = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Held low during reset so a source never sees a phantom accept.
                cmd_ready = !fifo_full && !i_rst;
                if (bus.i_cmd_valid && cmd_ready) begin
                    exe_a_d  = bus.i_cmd_a;
                    exe_b_d  = bus.i_cmd_b;
                    exe_op_d = bus.i_cmd_op;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and operand registers; reset discards any in-flight command.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            exe_a_q  <= '0;
            exe_b_q  <= '0;
            exe_op_q <= '0;
        end else begin
            state_q  <= state_d;
            exe_a_q  <= exe_a_d;
            exe_b_q  <= exe_b_d;
            exe_op_q <= exe_op_d;
        end
    end

    // FIFO pointer/occupancy bookkeeping and saturating error count.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (push && bus.i_exe_status[`ERROR_BIT] && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // FIFO control registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // FIFO storage; contents are only visible through a valid head so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= bus.i_exe_out;
            mem_stat_q[wr_ptr_q] <= bus.i_exe_status;
        end
    end

`ifdef EXE_DRV_CHECK_EN
    logic chk_fail_q, chk_fail_d;
    int   zero_cnt;
    logic exp_even;
    logic exp_single;

    // Recompute parity flags from the captured result and latch any disagreement.
    always_comb begin
        zero_cnt   = $countones(~bus.i_exe_out);
        exp_even   = ((zero_cnt % 2) == 0);
        exp_single = (zero_cnt == 1);
        chk_fail_d = chk_fail_q;
        if (push && ((exp_even   != bus.i_exe_status[`EVEN_BIT]) ||
                     (exp_single != bus.i_exe_status[`SINGLE_BIT]))) begin
            chk_fail_d = 1'b1;
        end
    end

    // Sticky failure flag, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chk_fail_q <= 1'b0;
        end else begin
            chk_fail_q <= chk_fail_d;
        end
    end

    assign bus.o_chk_fail = chk_fail_q;
`else
    assign bus.o_chk_fail = 1'b0;
`endif

    assign bus.o_cmd_ready  = cmd_ready;
    assign bus.o_exe_a      = exe_a_q;
    assign bus.o_exe_b      = exe_b_q;
    assign bus.o_exe_op     = exe_op_q;
    assign bus.o_res_valid  = !fifo_empty;
    assign bus.o_res_data   = fifo_empty ? '0 : mem_data_q[rd_ptr_q];
    assign bus.o_res_status = fifo_empty ? '0 : mem_stat_q[rd_ptr_q];
    assign bus.o_err_cnt    = err_cnt_q;
endmodule

// File: doc/exe_cmd_driver.md
Name: exe_cmd_driver

Overview:
- Initiator side of the execution-unit interface: accepts operation commands over a valid/ready handshake and drives operand/opcode inputs of the exe unit.
- Waits out the exe unit's registered-input latency, captures its result and 4-bit status, and buffers them in a result FIFO for a downstream consumer.
- Sits between the command source (test sequencer or controller) and the exe unit in the top-level datapath.

Parameters:
- BITS, 8, operand/result width; must match the exe unit.
- DEPTH, 4, result FIFO entries; power of 2, minimum 2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  driver can accept a command.
- i_cmd_a  in  BITS  operand A.
- i_cmd_b  in  BITS  operand B.
- i_cmd_op  in  2  opcode: 00 sub, 01 compare, 10 shift, 11 bit-change.
- o_exe_a  out  BITS  to exe unit in_a.
- o_exe_b  out  BITS  to exe unit in_b.
- o_exe_op  out  2  to exe unit i_op.
- i_exe_out  in  BITS  exe unit result.
- i_exe_status  in  4  exe unit status; bit indices come from the shared macros header (OVF_BIT, ERROR_BIT, EVEN_BIT, SINGLE_BIT).
- o_res_valid  out  1  FIFO non-empty.
- i_res_ready  in  1  consumer pops the head entry.
- o_res_data  out  BITS  head result.
- o_res_status  out  4  head status.
- o_err_cnt  out  8  count of captured results with ERROR_BIT set.
- o_chk_fail  out  1  sticky self-check failure (see Optional Feature).

Behaviour:
- Reset (async, on i_rst=1): state IDLE; o_exe_a/b/op=0; FIFO empty; o_res_valid=0; o_res_data/o_res_status=0; o_err_cnt=0; o_chk_fail=0; any in-flight command is discarded.
- The integration ties the exe unit's own active-low synchronous reset to ~i_rst. This is outside this block.
- State machine states: IDLE, LOAD, EVAL.
- IDLE: o_cmd_ready = !fifo_full.
  - A handshake occurs when i_cmd_valid && o_cmd_ready at a rising edge.
  - On a handshake, o_exe_a/b/op are registered from i_cmd_* and the state goes to LOAD.
- LOAD: o_cmd_ready=0. At the next edge the exe unit samples o_exe_*; state goes to EVAL.
- EVAL: o_cmd_ready=0. At the next edge, {i_exe_out, i_exe_status} is pushed into the FIFO and the state returns to IDLE.
- o_exe_* hold their last value outside handshakes.
- Latency: handshake at edge N, push at edge N+2, o_res_valid=1 after edge N+2 if the FIFO was empty. Maximum throughput is one command per 3 cycles.
- FIFO: first-word-fall-through. o_res_data/o_res_status always show the head entry and are 0 when empty.
  - Pop occurs when o_res_valid && i_res_ready.
  - Pointers wrap modulo DEPTH.
  - Occupancy counter is width clog2(DEPTH)+1.
- No overflow by construction: a command is only accepted when a slot is free, and only one command is in flight. Pop during LOAD/EVAL is legal.
- Push and pop on the same edge: occupancy unchanged, both pointers advance. Pop on an empty FIFO is ignored.
- o_err_cnt increments on each push whose status has ERROR_BIT=1. It saturates at 255 and is cleared only by reset.
- i_cmd_valid while not ready: the command is not consumed. The source must hold it (standard valid/ready).

Optional Feature:
- Macro EXE_DRV_CHECK_EN.
- Defined: on each push, the driver recomputes the parity flags from i_exe_out.
  - z = number of zero bits.
  - Expected EVEN = (z even).
  - Expected SINGLE = (z == 1).
  - Any mismatch with i_exe_status EVEN_BIT/SINGLE_BIT sets o_chk_fail=1, sticky until reset.
- Not defined: o_chk_fail is constant 0 and no checker logic is synthesized.

Test Plan:
- Reset then idle: i_rst=1 mid-LOAD -> immediately o_cmd_ready=0, o_res_valid=0, o_err_cnt=0. After release, o_cmd_ready=1 and no push ever occurs for the aborted command.
- Basic sub with real exe unit, BITS=8: handshake a=5, b=3, op=00 at edge 0 -> o_exe_a=5 after edge 0; o_res_valid=1 after edge 2; o_res_data=8'h02; EVEN_BIT=0, SINGLE_BIT=0, ERROR_BIT=0; pop clears o_res_valid.
- Parity boundary: op=00, a=8'hFF, b=8'h01 -> o_res_data=8'hFE, SINGLE_BIT=1, EVEN_BIT=0. With EXE_DRV_CHECK_EN defined, o_chk_fail stays 0.
- Backpressure, DEPTH=4: i_res_ready=0, 5 commands offered back-to-back -> 4 accepted (edges 0, 3, 6, 9), o_cmd_ready=0 from edge 11. One pop -> o_cmd_ready=1 next cycle and the 5th command is accepted. Data pops out in issue order.
- Error counter with stub exe unit forcing ERROR_BIT=1 on every result: 300 commands -> o_err_cnt saturates at 255.
- Checker, with EXE_DRV_CHECK_EN: stub returns i_exe_out=8'h00 with EVEN_BIT=0 -> o_chk_fail=1 after the push edge and stays 1 through later correct results until reset.
